// File: rtl/sub32_pipe.sv
// Two-stage pipelined 32-bit subtractor (a + ~b + 1) split into 16-bit halves,
// with valid/ready handshakes and borrow/overflow/zero flags on the output.
module sub32_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] diff,
    output logic        borrow,
    output logic        overflow,
    output logic        zero
);

    logic        r_s1_valid;
    logic [15:0] r_s1_lo;
    logic        r_s1_c;
    logic [15:0] r_s1_ahi;
    logic [15:0] r_s1_bhi;

    logic        r_out_valid;
    logic [31:0] r_diff;
    logic        r_borrow;
    logic        r_overflow;
    logic        r_zero;

    logic        w_out_adv;
    logic [16:0] w_lo_sum;
    logic [16:0] w_hi_sum;
    logic [31:0] w_diff;
    logic        w_overflow;

    assign w_out_adv = !r_out_valid | out_ready;
    assign in_ready  = !r_s1_valid | w_out_adv;

    // Low half absorbs the "+1" of two's-complement negation; its carry feeds stage 2.
    assign w_lo_sum = {1'b0, a[15:0]} + {1'b0, ~b[15:0]} + 17'd1;
    assign w_hi_sum = {1'b0, r_s1_ahi} + {1'b0, ~r_s1_bhi} + {16'd0, r_s1_c};

    assign w_diff     = {w_hi_sum[15:0], r_s1_lo};
    assign w_overflow = (r_s1_ahi[15] ^ r_s1_bhi[15]) & (r_s1_ahi[15] ^ w_diff[31]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_lo    <= 16'd0;
            r_s1_c     <= 1'b0;
            r_s1_ahi   <= 16'd0;
            r_s1_bhi   <= 16'd0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_lo  <= w_lo_sum[15:0];
                r_s1_c   <= w_lo_sum[16];
                r_s1_ahi <= a[31:16];
                r_s1_bhi <= b[31:16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_diff      <= 32'd0;
            r_borrow    <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_out_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff     <= w_diff;
                r_borrow   <= ~w_hi_sum[16];
                r_overflow <= w_overflow;
                r_zero     <= (w_diff == 32'd0);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule

// File: tb/tb_sub32_pipe.sv
// Directed self-checking bench for sub32_pipe: arithmetic vectors, latency,
// streaming, backpressure and mid-stream reset.
module tb_sub32_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;

    int pass_cnt = 0;
    int total_cnt = 0;

    sub32_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Hand-computed vectors: a, b, diff, borrow, overflow, zero
    logic [31:0] tv_a [6] = '{32'd5, 32'h0001_0000, 32'd0, 32'h8000_0000, 32'h1234_5678, 32'h7FFF_FFFF};
    logic [31:0] tv_b [6] = '{32'd3, 32'd1, 32'd1, 32'd1, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [31:0] tv_d [6] = '{32'd2, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'h8000_0000};
    logic        tv_bo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        tv_ov [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        tv_z  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    logic [31:0] st_a [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
    logic [31:0] st_b [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic [31:0] st_d [4] = '{32'd9, 32'd18, 32'd27, 32'd36};

    logic [31:0] bp_a [4] = '{32'h100, 32'h200, 32'h300, 32'h400};
    logic [31:0] bp_d [4] = '{32'hFF, 32'h1FF, 32'h2FF, 32'h3FF};

    task automatic test_reset;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if ({diff, borrow, overflow, zero} !== 35'd0)
            $display("FAIL reset_outputs got diff=%h b=%b o=%b z=%b exp all 0", diff, borrow, overflow, zero);
        else pass_cnt++;
        $display("reset: out_valid=%b in_ready=%b diff=%h", out_valid, in_ready, diff);
    endtask

    // Each vector alone: accept at edge k, result at k+1, drained after k+2.
    task automatic test_arith;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = tv_a[i]; b = tv_b[i]; out_ready = 1'b1;
            #1;
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL arith%0d_in_ready got=%b exp=1", i, in_ready);
            else pass_cnt++;
            @(posedge clk); #1;
            in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL arith%0d_early_valid got=%b exp=0", i, out_valid);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b1 || diff !== tv_d[i] || borrow !== tv_bo[i] ||
                overflow !== tv_ov[i] || zero !== tv_z[i])
                $display("FAIL arith%0d got v=%b d=%h b=%b o=%b z=%b exp v=1 d=%h b=%b o=%b z=%b",
                         i, out_valid, diff, borrow, overflow, zero, tv_d[i], tv_bo[i], tv_ov[i], tv_z[i]);
            else pass_cnt++;
            $display("arith%0d: %h - %h = %h b=%b o=%b z=%b", i, tv_a[i], tv_b[i], diff, borrow, overflow, zero);
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL arith%0d_drain got=%b exp=0", i, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = st_a[i]; b = st_b[i];
            @(posedge clk); #1;
            if (i >= 1) begin
                total_cnt++;
                if (out_valid !== 1'b1 || diff !== st_d[i-1])
                    $display("FAIL b2b%0d got v=%b d=%h exp v=1 d=%h", i - 1, out_valid, diff, st_d[i-1]);
                else pass_cnt++;
                $display("b2b%0d: diff=%h", i - 1, diff);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b1 || diff !== st_d[3])
            $display("FAIL b2b3 got v=%b d=%h exp v=1 d=%h", out_valid, diff, st_d[3]);
        else pass_cnt++;
        $display("b2b3: diff=%h", diff);
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        int acc;
        int rcv;
        acc = 0;
        rcv = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; a = bp_a[acc]; b = 32'd1;
            #1;
            if (c == 2) begin
                total_cnt++;
                if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got=%b exp=0", in_ready);
                else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++;
                if (out_valid !== 1'b1 || diff !== bp_d[0])
                    $display("FAIL bp_hold got v=%b d=%h exp v=1 d=%h", out_valid, diff, bp_d[0]);
                else pass_cnt++;
            end
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (acc != 2) $display("FAIL bp_accepted got=%0d exp=2", acc);
        else pass_cnt++;
        $display("bp: accepted %0d while stalled", acc);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && rcv < 4; c++) begin
            in_valid = (acc < 4);
            if (acc < 4) begin a = bp_a[acc]; b = 32'd1; end
            #1;
            if (out_valid) begin
                total_cnt++;
                if (diff !== bp_d[rcv]) $display("FAIL bp_order%0d got=%h exp=%h", rcv, diff, bp_d[rcv]);
                else pass_cnt++;
                $display("bp: result %0d diff=%h", rcv, diff);
                rcv++;
            end
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (rcv != 4 || acc != 4) $display("FAIL bp_count got rcv=%0d acc=%0d exp 4/4", rcv, acc);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = st_a[i]; b = st_b[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 32'd0)
            $display("FAIL midrst got v=%b rdy=%b d=%h exp v=0 rdy=1 d=0", out_valid, in_ready, diff);
        else pass_cnt++;
        $display("midrst: out_valid=%b in_ready=%b", out_valid, in_ready);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL midrst_stale%0d got v=%b d=%h exp v=0", i, out_valid, diff);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #3;
        test_reset;
        #19;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_arith;
        test_back_to_back;
        test_backpressure;
        test_reset_midstream;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
